// File: rtl/eth_frame_tx.sv
// Ethernet MAC transmit framer.
// Builds one frame per accepted request: destination MAC, source MAC,
// EtherType, payload (show-ahead source), zero pad up to the minimum
// payload size, then the 32-bit FCS. Preamble/SFD and inter-frame gap are
// added by the downstream transmitter, whose `phy_active` flag gates the
// start of every new frame.
//
// Handshake: `tx_request` is a level. It is sampled only in IDLE, and only
// while `phy_active` is low. Acceptance latches all header fields and the
// clamped length, and is signalled by a one-cycle `tx_ack`. The first
// `tx_enable` byte follows one cycle after `tx_ack`. Payload bytes are
// consumed with `payload_rd`: the byte on `payload_data` in a cycle with
// `payload_rd` high is the byte sent on `data` in that cycle and is
// considered read at the following clock edge.
module eth_frame_tx #(
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tx_request,
    output logic        tx_ack,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] ethertype,
    input  logic [10:0] payload_length,
    output logic        payload_rd,
    input  logic [7:0]  payload_data,
    input  logic        phy_active,
    output logic [7:0]  data,
    output logic        tx_enable,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [10:0] MIN_LEN   = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_LEN   = 11'(MAX_PAYLOAD);
    localparam logic [10:0] HDR_LAST  = 11'd13;
    localparam logic [10:0] FCS_LAST  = 11'd3;
    localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;

    // Each state names what the frame is emitting in the current cycle.
    // ACK is the single cycle in which tx_ack is high, before the first byte.
    typedef enum logic [2:0] {
        IDLE,
        ACK,
        HEADER,
        PAYLOAD,
        PAD,
        FCS,
        DONE
    } state_t;

    state_t       state;
    logic [10:0]  cnt;        // byte index inside the current phase
    logic [10:0]  len_q;      // clamped payload length of the frame in flight
    logic [111:0] hdr_q;      // dst/src/type, shifted out MSB byte first
    logic [23:0]  fcs_q;      // FCS bytes still to be sent after the first
    logic [31:0]  crc_q;      // running reflected CRC-32 register
    logic [7:0]   data_q;     // registered byte for header, pad and FCS
    logic [31:0]  crc_next;
    logic [31:0]  fcs_val;

    // One CRC-32 step over a whole byte, LSB first, reflected polynomial.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc,
                                             input logic [7:0]  b);
        logic [31:0] c;
        c = crc ^ {24'h000000, b};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) c = (c >> 1) ^ CRC_POLY;
            else      c = c >> 1;
        end
        return c;
    endfunction

    // Payload bytes come straight from the show-ahead source so the byte
    // sent is the byte consumed in the same cycle; all other bytes are
    // registered.
    assign data = payload_rd ? payload_data : data_q;

    // CRC is folded over whatever is on `data` this cycle; it is only
    // committed in HEADER, PAYLOAD and PAD.
    always_comb begin
        crc_next = crc_byte(crc_q, data);
        fcs_val  = ~crc_next;
    end

    // Frame sequencer: state, byte counter, CRC and all registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            len_q      <= '0;
            hdr_q      <= '0;
            fcs_q      <= '0;
            crc_q      <= CRC_INIT;
            data_q     <= '0;
            tx_ack     <= 1'b0;
            tx_enable  <= 1'b0;
            payload_rd <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx_ack     <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_request && !phy_active) begin
                        hdr_q  <= {dst_mac, src_mac, ethertype};
                        len_q  <= (payload_length > MAX_LEN) ? MAX_LEN
                                                             : payload_length;
                        tx_ack <= 1'b1;
                        state  <= ACK;
                    end
                end

                ACK: begin
                    // First header byte is presented the cycle after tx_ack.
                    state     <= HEADER;
                    cnt       <= '0;
                    tx_enable <= 1'b1;
                    busy      <= 1'b1;
                    data_q    <= hdr_q[111:104];
                    hdr_q     <= hdr_q << 8;
                end

                HEADER: begin
                    crc_q <= crc_next;
                    if (cnt == HDR_LAST) begin
                        cnt    <= '0;
                        data_q <= 8'h00;
                        if (len_q != 11'd0) begin
                            state      <= PAYLOAD;
                            payload_rd <= 1'b1;
                        end else begin
                            state <= PAD;
                        end
                    end else begin
                        cnt    <= cnt + 11'd1;
                        data_q <= hdr_q[111:104];
                        hdr_q  <= hdr_q << 8;
                    end
                end

                PAYLOAD: begin
                    crc_q <= crc_next;
                    if (cnt == len_q - 11'd1) begin
                        cnt        <= '0;
                        payload_rd <= 1'b0;
                        if (len_q < MIN_LEN) begin
                            state  <= PAD;
                            data_q <= 8'h00;
                        end else begin
                            state  <= FCS;
                            data_q <= fcs_val[7:0];
                            fcs_q  <= fcs_val[31:8];
                        end
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end

                PAD: begin
                    // Pad bytes are zero and still covered by the FCS.
                    crc_q <= crc_next;
                    if (cnt == MIN_LEN - len_q - 11'd1) begin
                        cnt    <= '0;
                        state  <= FCS;
                        data_q <= fcs_val[7:0];
                        fcs_q  <= fcs_val[31:8];
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end

                FCS: begin
                    if (cnt == FCS_LAST) begin
                        cnt        <= '0;
                        state      <= DONE;
                        tx_enable  <= 1'b0;
                        busy       <= 1'b0;
                        data_q     <= 8'h00;
                        frame_done <= 1'b1;
                        crc_q      <= CRC_INIT;
                    end else begin
                        cnt    <= cnt + 11'd1;
                        data_q <= fcs_q[7:0];
                        fcs_q  <= fcs_q >> 8;
                    end
                end

                DONE: begin
                    // phy_active from the downstream gap holds off the
                    // next accept once back in IDLE.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/eth_frame_tx.md
Name: eth_frame_tx

Overview:
- Ethernet MAC transmit framer. Sits directly upstream of the RGMII transmitter and drives its `data`/`tx_enable` byte stream.
- Per request it builds one frame: destination MAC, source MAC, EtherType, payload pulled from a show-ahead source, zero padding to minimum length, then the 32-bit FCS.
- Preamble/SFD and inter-frame gap are inserted downstream. This block waits on the downstream `active` flag before starting the next frame.

Parameters:
- MIN_PAYLOAD, 46, payload+pad byte count below which zero padding is added.
- MAX_PAYLOAD, 1500, payload_length clamp value.

Ports:
- clock  in  1  125 MHz transmit clock (same clock as the RGMII transmitter's `clock` output).
- reset_n  in  1  synchronous, active-low reset.
- tx_request  in  1  level; frame pending, header fields and length valid.
- tx_ack  out  1  one-cycle pulse; request accepted, fields latched.
- dst_mac  in  48  destination MAC; [47:40] sent first.
- src_mac  in  48  source MAC; [47:40] sent first.
- ethertype  in  16  [15:8] sent first.
- payload_length  in  11  payload bytes, 0..2047; clamped to MAX_PAYLOAD.
- payload_rd  out  1  consume strobe; payload_data valid in the same cycle (show-ahead).
- payload_data  in  8  current payload byte.
- phy_active  in  1  downstream transmitter busy (send/purge/gap).
- data  out  8  byte to transmitter.
- tx_enable  out  1  frame byte valid; high contiguously for the whole frame.
- busy  out  1  high from accept through last FCS byte.
- frame_done  out  1  one-cycle pulse after last FCS byte.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-low on `reset_n`.
- Reset values: `data`=0, `tx_enable`=0, `payload_rd`=0, `tx_ack`=0, `busy`=0, `frame_done`=0, state=IDLE, CRC register=32'hFFFFFFFF.
- IDLE:
  - If `tx_request` & !`phy_active`: latch `dst_mac`, `src_mac`, `ethertype`, len=min(`payload_length`, MAX_PAYLOAD); pulse `tx_ack`; go to HEADER.
  - If `tx_request` & `phy_active`: stay in IDLE, no ack.
- HEADER: 14 cycles. `tx_enable`=1; `data` = dst[47:40]..dst[7:0], src[47:40]..src[7:0], type[15:8], type[7:0].
  - First `tx_enable` cycle is the cycle after `tx_ack`.
  - Exit to PAYLOAD if len>0; else to PAD.
- PAYLOAD: len cycles. `payload_rd`=1 and `data`=`payload_data` in each cycle; exactly len strobes per frame.
  - Exit to PAD if len<MIN_PAYLOAD; else to FCS.
- PAD: (MIN_PAYLOAD−len) cycles, `data`=8'h00, `payload_rd`=0. Then go to FCS.
- FCS: 4 cycles.
  - fcs = ~crc, where crc uses the reflected polynomial 32'hEDB88320, init 32'hFFFFFFFF, LSB-first per byte.
  - Coverage: header, payload and pad bytes.
  - Bytes sent in order fcs[7:0], [15:8], [23:16], [31:24].
  - CRC update is byte-parallel, one byte per clock, over the value on `data` in HEADER/PAYLOAD/PAD.
- DONE: `tx_enable`=0, `data`=0, `busy`=0, `frame_done`=1 for one cycle. CRC re-initialised; go to IDLE.
  - A new frame cannot start before `phy_active` falls, which includes the downstream purge and gap.
- `tx_enable` high-cycle count per frame = 18 + max(len, MIN_PAYLOAD). No gaps inside a frame.
- `busy` is high from the `tx_ack` cycle's next edge until the DONE cycle.
- `tx_request` and header inputs are ignored while `busy`. Changes after `tx_ack` do not affect the frame in flight.
- Length rules:
  - len=0 → 46 pad bytes.
  - len=46 → no pad.
  - len=1500 → no pad.
  - `payload_length`>1500 → exactly 1500 strobes; the excess source bytes are left unread (the source's responsibility).
- Mid-frame reset: the next edge forces all outputs to their reset values. No FCS is emitted. The downstream block purges.
- Arithmetic: byte counter 11 bits, compared with `==` at end of each phase; no wrap is possible within the clamped length.

Test Plan:
- len=64, incrementing payload, `phy_active`=0 → `tx_ack` at accept edge; `tx_enable` high exactly 82 cycles; 64 `payload_rd` strobes; FCS matches software CRC-32 of 78 bytes; `frame_done` one cycle after.
- len=0 → 14 header bytes + 46 zero bytes + 4 FCS; 64 `tx_enable` cycles; zero `payload_rd`; FCS matches model.
- len=10 → 10 strobes, 36 pad bytes, 64 total cycles.
- len=2000 → 1500 strobes, no pad, 1518 `tx_enable` cycles.
- `tx_request` held while `phy_active`=1 for 20 cycles → no `tx_ack`, `tx_enable` stays 0; ack in first cycle with `phy_active`=0, `tx_enable` one cycle later.
- `reset_n` low during PAYLOAD byte 5 → next edge: `tx_enable`=0, `payload_rd`=0, `busy`=0. After release, a new request produces a correct frame with a fresh CRC.
